// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, largest legal digit, subtractor FSM
// encoding and the nine's-complement helper.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] digit);
        return BCD_MAX - digit;
    endfunction

    function automatic logic digit_bad(input logic [DIGIT_W-1:0] digit);
        return (digit > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_adder_1digit.sv
// One-digit BCD adder: {cout, s} = a + b + cin with decimal correction.
module bcd_adder_1digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    logic [DIGIT_W:0] raw;

    // Binary sum, then add 6 when it leaves the decimal range
    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        if (raw > 5'd9) begin
            s    = raw[DIGIT_W-1:0] + 4'd6;
            cout = 1'b1;
        end else begin
            s    = raw[DIGIT_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock,
// computed as a + (9 - b) + ~bin through a single shared digit adder.
module bcd_subtractor_serial
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIGIT_W*NDIGITS-1:0] a,
    input  logic [DIGIT_W*NDIGITS-1:0] b,
    input  logic                       bin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIGIT_W*NDIGITS-1:0] diff,
    output logic                       bout,
    output logic                       err
);

    localparam int W     = DIGIT_W * NDIGITS;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    state_t             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       diff_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               err_q;
    logic               bout_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [DIGIT_W-1:0] a_digit;
    logic [DIGIT_W-1:0] b_digit;
    logic [DIGIT_W-1:0] add_sum;
    logic               add_cout;
    logic               bad_digit;

    // Select the current digit pair; subtrahend enters in nine's complement
    always_comb begin
        a_digit = a_q[idx_q*DIGIT_W +: DIGIT_W];
        b_digit = nines_comp(b_q[idx_q*DIGIT_W +: DIGIT_W]);
    end

    // Flag any non-decimal digit on the operands being offered
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            bad_digit = bad_digit | digit_bad(a[i*DIGIT_W +: DIGIT_W])
                                  | digit_bad(b[i*DIGIT_W +: DIGIT_W]);
        end
    end

    bcd_adder_1digit u_digit_adder (
        .a    (a_digit),
        .b    (b_digit),
        .cin  (carry_q),
        .s    (add_sum),
        .cout (add_cout)
    );

    // Control FSM plus operand, result and handshake registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= ~bin;
                        idx_q      <= '0;
                        err_q      <= bad_digit;
                        diff_q     <= '0;
                        bout_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    diff_q[idx_q*DIGIT_W +: DIGIT_W] <= add_sum;
                    carry_q <= add_cout;
                    idx_q   <= idx_q + 1'b1;
                    // Final carry of the complement sum is the inverse of the borrow
                    if (idx_q == LAST_IDX) begin
                        bout_q      <= ~add_cout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Directed self-checking bench for bcd_subtractor_serial (NDIGITS = 4).
module tb_bcd_subtractor_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        err;

    int checks = 0;
    int errors = 0;

    bcd_subtractor_serial #(.NDIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: offer one operation, measure latency, check result,
    // optionally stall the consumer for hold cycles, then drain.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vbin, input logic [15:0] exp_diff, input logic exp_bout,
                          input logic exp_err, input int hold);
        int n;
        check({tag, "_in_ready"}, in_ready, 1);
        a = va; b = vb; bin = vbin; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'h7777; b = 16'h3333; bin = 1'b1;
        check({tag, "_busy"}, in_ready, 0);
        n = 0;
        while (n < 20) begin
            if (out_valid) break;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_err"}, err, exp_err);
        if (!exp_err) begin
            check({tag, "_diff"}, diff, exp_diff);
            check({tag, "_bout"}, bout, exp_bout);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 3);
            a = 16'h1111; b = 16'h0000; bin = 1'b0;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_ready"}, in_ready, 0);
            check({tag, "_hold_diff"}, diff, exp_diff);
            check({tag, "_hold_bout"}, bout, exp_bout);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, out_valid, 0);
        check({tag, "_drain_ready"}, in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; bin = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("basic",   16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 0);
        run_op("neg1",    16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 0);
        run_op("chain",   16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0, 0);
        run_op("allnine", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 0);
        run_op("zero",    16'h5000, 16'h4999, 1'b1, 16'h0000, 1'b0, 1'b0, 0);
        run_op("baddig",  16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 0);
        run_op("clean",   16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0, 0);
        run_op("stall",   16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 10);
        // A dropped in_valid pulse during the stall must not have started an op
        check("after_stall_idle_valid", out_valid, 0);
        run_op("post",    16'h0300, 16'h0150, 1'b0, 16'h0150, 1'b0, 1'b0, 0);

        // Abort in CALC once two digits are done (idx = 2)
        a = 16'h00A0; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pre_abort_diff_nonzero", (diff != 16'h0), 1);
        rst = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        check("abort_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("after_abort", 16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
